// File: rtl/leaky_relu_stage.sv
// Leaky-ReLU activation/gradient stage with a sign-history FIFO; build with LEAKY_RELU_SAT_EN to saturate scaled results instead of wrapping.
// Latency 2 cycles, 1 sample/cycle; no backpressure (no ready), FIFO overflow/underflow are flagged in sticky bits.
module leaky_relu_stage #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lr_valid_in,
    input  logic             lr_backward_in,
    input  logic [WIDTH-1:0] lr_data_in,
    output logic [WIDTH-1:0] lr_data_out,
    output logic             lr_valid_out,
    input  logic             lr_leak_load_in,
    input  logic [WIDTH-1:0] lr_leak_in,
    output logic [WIDTH-1:0] lr_leak_out,
    input  logic             lr_clear_in,
    output logic [CW-1:0]    lr_count_out,
    output logic [1:0]       lr_err_out
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SEL_IDENT = 2'd0,
        SEL_SCALE = 2'd1,
        SEL_ZERO  = 2'd2
    } sel_e;

    logic [WIDTH-1:0] leak_q;
    logic             s1_vld_q;
    logic [WIDTH-1:0] s1_data_q;
    logic [WIDTH-1:0] s1_leak_q;
    sel_e             s1_sel_q;
    logic             out_vld_q;
    logic [WIDTH-1:0] out_dat_q;
    logic [DEPTH-1:0] sign_q, sign_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, udf_q;

    logic fwd, bwd, x_pos, empty, full;
    logic ovf_set, udf_set;
    sel_e sel_d;

    // Stage-1 decision: which result path the sample takes, plus FIFO bookkeeping.
    always_comb begin
        fwd      = lr_valid_in & ~lr_backward_in;
        bwd      = lr_valid_in & lr_backward_in;
        x_pos    = ~lr_data_in[WIDTH-1] & (|lr_data_in);
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        sel_d    = SEL_SCALE;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        sign_d   = sign_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (fwd) begin
            sel_d = x_pos ? SEL_IDENT : SEL_SCALE;
        end else if (bwd && !lr_clear_in) begin
            if (empty) begin
                sel_d = SEL_ZERO;
            end else begin
                sel_d = sign_q[rd_ptr_q] ? SEL_IDENT : SEL_SCALE;
            end
        end

        if (lr_clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (fwd) begin
            if (full) begin
                ovf_set = 1'b1;
            end else begin
                sign_d[wr_ptr_q] = x_pos;
                wr_ptr_d         = wr_ptr_q + PW'(1);
                count_d          = count_q + CW'(1);
            end
        end else if (bwd) begin
            if (empty) begin
                udf_set = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                count_d  = count_q - CW'(1);
            end
        end
    end

    logic signed [2*WIDTH-1:0] prod, shifted;
    logic [WIDTH-1:0]          scaled, res_d;

    always_comb begin
        prod    = $signed({{WIDTH{s1_data_q[WIDTH-1]}}, s1_data_q})
                * $signed({{WIDTH{s1_leak_q[WIDTH-1]}}, s1_leak_q});
        shifted = prod >>> FRAC;
`ifdef LEAKY_RELU_SAT_EN
        // Result fits iff every bit above the target sign bit matches it.
        if ((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1])) begin
            scaled = shifted[WIDTH-1:0];
        end else if (shifted[2*WIDTH-1]) begin
            scaled = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            scaled = {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        scaled = shifted[WIDTH-1:0];
`endif
        case (s1_sel_q)
            SEL_IDENT: res_d = s1_data_q;
            SEL_SCALE: res_d = scaled;
            default:   res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leak_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_leak_q <= '0;
            s1_sel_q  <= SEL_IDENT;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            sign_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (lr_leak_load_in) begin
                leak_q <= lr_leak_in;
            end
            s1_vld_q <= lr_valid_in;
            if (lr_valid_in) begin
                s1_data_q <= lr_data_in;
                s1_leak_q <= leak_q;
                s1_sel_q  <= sel_d;
            end
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_dat_q <= res_d;
            end
            sign_q   <= sign_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_q | ovf_set;
            udf_q    <= udf_q | udf_set;
        end
    end

    assign lr_data_out  = out_dat_q;
    assign lr_valid_out = out_vld_q;
    assign lr_leak_out  = leak_q;
    assign lr_count_out = count_q;
    assign lr_err_out   = {udf_q, ovf_q};

endmodule

// File: tb/tb_leaky_relu_stage.sv
// Directed bench for leaky_relu_stage (DEPTH=4): scoreboard queue of expected outputs checked by a monitor.
module tb_leaky_relu_stage;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic          bwd = 1'b0;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  dout;
    logic          vout;
    logic          load = 1'b0;
    logic [W-1:0]  leak = '0;
    logic [W-1:0]  leak_out;
    logic          clr = 1'b0;
    logic [CW-1:0] count;
    logic [1:0]    err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;
    exp_t exp_q[$];

    leaky_relu_stage #(.WIDTH(W), .FRAC(8), .DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .lr_valid_in    (vin),
        .lr_backward_in (bwd),
        .lr_data_in     (din),
        .lr_data_out    (dout),
        .lr_valid_out   (vout),
        .lr_leak_load_in(load),
        .lr_leak_in     (leak),
        .lr_leak_out    (leak_out),
        .lr_clear_in    (clr),
        .lr_count_out   (count),
        .lr_err_out     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every valid output must match the oldest expectation, at the expected cycle.
    always @(negedge clk) begin
        if (vout) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {16'h0, dout}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("data_out", {16'h0, dout}, {16'h0, e.d});
                chk("latency", cyc, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic [W-1:0] d, input logic [W-1:0] expd);
        exp_t e;
        vin = 1'b1;
        bwd = b;
        din = d;
        e.d = expd;
        e.c = cyc + 2;
        exp_q.push_back(e);
        tick();
        vin = 1'b0;
        bwd = 1'b0;
    endtask

    task automatic load_leak(input logic [W-1:0] v);
        load = 1'b1;
        leak = v;
        tick();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [W-1:0] sat_exp;
`ifdef LEAKY_RELU_SAT_EN
        sat_exp = 16'h8000;
`else
        sat_exp = 16'h0000;
`endif
        idle(2);
        rst = 1'b0;
        chk("rst_valid", {31'h0, vout}, 32'h0);
        chk("rst_data", {16'h0, dout}, 32'h0);
        chk("rst_leak", {16'h0, leak_out}, 32'h0);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_err", {30'h0, err}, 32'h0);

        // Forward values
        load_leak(16'h0040);
        chk("leak_cascade", {16'h0, leak_out}, 32'h0040);
        send(1'b0, 16'h0200, 16'h0200);
        send(1'b0, 16'hFE00, 16'hFF80);
        send(1'b0, 16'h0000, 16'h0000);
        send(1'b0, 16'hFFFF, 16'hFFFF);
        chk("fwd_count", {29'h0, count}, 32'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_full", {29'h0, count}, 32'd0);
        idle(2);

        // Backward
        send(1'b0, 16'h0100, 16'h0100);
        send(1'b0, 16'hFF00, 16'hFFC0);
        chk("bwd_count2", {29'h0, count}, 32'd2);
        send(1'b1, 16'h0200, 16'h0200);
        send(1'b1, 16'h0200, 16'h0080);
        chk("bwd_count0", {29'h0, count}, 32'd0);
        chk("bwd_err", {30'h0, err}, 32'h0);
        idle(2);

        // Saturation / wrap
        load_leak(16'h0400);
        send(1'b0, 16'hC000, sat_exp);
        send(1'b1, 16'h0010, 16'h0040);
        idle(2);

        // FIFO bounds
        send(1'b0, 16'h0100, 16'h0100);
        send(1'b0, 16'hFF00, 16'hFC00);
        send(1'b0, 16'h0200, 16'h0200);
        send(1'b0, 16'hFFF0, 16'hFFC0);
        send(1'b0, 16'h0300, 16'h0300);
        chk("ovf_count", {29'h0, count}, 32'd4);
        chk("ovf_err", {30'h0, err}, 32'h1);
        send(1'b1, 16'h0010, 16'h0010);
        send(1'b1, 16'h0010, 16'h0040);
        send(1'b1, 16'h0010, 16'h0010);
        send(1'b1, 16'h0010, 16'h0040);
        send(1'b1, 16'h0010, 16'h0000);
        chk("udf_count", {29'h0, count}, 32'd0);
        chk("udf_err", {30'h0, err}, 32'h3);
        idle(2);

        // Load/clear collisions
        load_leak(16'h0040);
        load = 1'b1;
        leak = 16'h0080;
        send(1'b0, 16'hFF00, 16'hFFC0);
        load = 1'b0;
        chk("leak_new", {16'h0, leak_out}, 32'h0080);
        send(1'b0, 16'hFF00, 16'hFF80);
        send(1'b0, 16'h0100, 16'h0100);
        chk("count3", {29'h0, count}, 32'd3);
        clr = 1'b1;
        send(1'b1, 16'h0200, 16'h0100);
        clr = 1'b0;
        chk("clear_count", {29'h0, count}, 32'd0);
        idle(3);
        chk("drain_mid", exp_q.size(), 32'd0);

        // Reset with two samples in flight
        vin = 1'b1;
        din = 16'h0100;
        tick();
        din = 16'h0200;
        rst = 1'b1;
        tick();
        vin = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_flight_valid", {31'h0, vout}, 32'h0);
            tick();
        end
        chk("rst_flight_data", {16'h0, dout}, 32'h0);
        chk("rst_flight_err", {30'h0, err}, 32'h0);
        chk("rst_flight_count", {29'h0, count}, 32'd0);
        chk("rst_flight_leak", {16'h0, leak_out}, 32'h0);

        idle(2);
        chk("drain_end", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/leaky_relu_stage.md
Name: leaky_relu_stage

Overview:
- Per-column activation stage directly downstream of the bias stage; consumes y+b (forward) or upstream gradient (backward) and produces the activated value or local gradient.
- Forward: leaky ReLU with a loadable, cascaded leak factor; records each forward sample's sign in a small FIFO.
- Backward: pops recorded signs and scales incoming gradients by 1 or leak.
- 2-cycle pipeline, signed Q8.8 fixed point.

Parameters:
- WIDTH, 16, data width (signed two's complement)
- FRAC, 8, fractional bits (Q8.8 at defaults)
- DEPTH, 16, sign-history FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lr_valid_in  in  1  input sample valid
- lr_backward_in  in  1  qualifies lr_valid_in: 1 = gradient (backward), 0 = activation (forward)
- lr_data_in  in  WIDTH  y+b from bias stage, or gradient
- lr_data_out  out  WIDTH  activated value or local gradient
- lr_valid_out  out  1  lr_data_out valid
- lr_leak_load_in  in  1  load leak factor
- lr_leak_in  in  WIDTH  leak factor, Q8.8
- lr_leak_out  out  WIDTH  registered cascade of lr_leak_in to next column
- lr_clear_in  in  1  flush sign FIFO
- lr_count_out  out  clog2(DEPTH+1)  FIFO occupancy
- lr_err_out  out  2  sticky {underflow, overflow}

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is synchronous, active-high, and clears all state in one edge. Reset values: lr_data_out=0, lr_valid_out=0, lr_leak_out=0, leak register=0, FIFO pointers/count=0, lr_err_out=0. In-flight pipeline data is discarded; lr_valid_out is 0 on the cycle after reset.
- Leak load: when lr_leak_load_in=1, the leak register and lr_leak_out take lr_leak_in at the edge. A sample accepted in the same cycle as a load uses the old leak.
- Pipeline:
  - Stage 1 registers data, mode, selected factor, and valid.
  - Stage 2 registers the result.
  - Latency is exactly 2 cycles; throughput is 1 sample/cycle.
  - lr_valid_out follows lr_valid_in delayed 2 cycles.
  - lr_data_out holds its value when no valid result is produced.
- lr_backward_in is ignored when lr_valid_in=0.
- Forward (valid=1, backward=0):
  - x>0: out = x, and push 1.
  - x<=0: out = scale(x), and push 0.
  - If the FIFO is full, the push is dropped and the overflow bit is set; the output is still produced.
- Backward (valid=1, backward=1):
  - Pop the oldest flag (FIFO order).
  - Flag 1: out = g. Flag 0: out = scale(g).
  - If the FIFO is empty, out = 0 and the underflow bit is set.
- scale(v) = (v * leak), full 2*WIDTH product, arithmetic shift right by FRAC (floor toward -inf), then reduced to WIDTH bits per the optional feature.
- lr_clear_in: resets pointers and count in one edge. It has priority over a push/pop in the same cycle; that sample's data is still processed, but no FIFO access occurs (a backward sample in the clear cycle uses flag 0, with no underflow flagged).
- lr_err_out bits are sticky and are cleared only by rst.
- lr_count_out is registered and reflects pushes/pops/clear of the previous edge.
- Push and pop never coincide, since mode is exclusive per cycle.

Optional Feature:
- LEAKY_RELU_SAT_EN
- Defined: scale() saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: scale() keeps the low WIDTH bits (wrap).
- The identity path is never affected.

Test Plan:
- Forward values: load leak 0x0040 (0.25); inputs 0x0200, 0xFE00, 0x0000, 0xFFFF, one per cycle → outputs 0x0200, 0xFF80, 0x0000, 0xFFFF, each 2 cycles after its input, with lr_valid_out pulses aligned; lr_leak_out=0x0040 one cycle after load.
- Backward: leak 0x0040; forward 0x0100 then 0xFF00; then backward 0x0200, 0x0200 → backward outputs 0x0200 then 0x0080; count 2→0; lr_err_out=00.
- Saturation: leak 0x0400 (4.0), forward 0xC000 → 0x8000 with LEAKY_RELU_SAT_EN, 0x0000 without.
- FIFO bounds (DEPTH=4): 5 forward samples → count=4, lr_err_out=01, all 5 outputs produced. Then 5 backward samples → first 4 scaled per recorded flags, fifth outputs 0, lr_err_out=11.
- Load/clear collisions: load leak 0x0080 in the same cycle as forward 0xFF00 with old leak 0x0040 → 0xFFC0; next 0xFF00 → 0xFF80. Assert lr_clear_in with count=3 → count=0 next cycle.
- Reset mid-stream: assert rst with 2 samples in flight → lr_valid_out=0 on the following cycles, all outputs and lr_err_out at 0.
